// File: rtl/blake2_pkg.sv
// Shared types and constants for the BLAKE2 G mixing unit.
// FSM encoding, word widths and the two rotation sets (BLAKE2s / BLAKE2b).
package blake2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      H0   = 2'd1,
      H1   = 2'd2,
      DONE = 2'd3
   } g_state_e;

   localparam int B2S_W  = 32;
   localparam int B2B_W  = 64;

   localparam int B2S_R1 = 16;
   localparam int B2S_R2 = 12;
   localparam int B2S_R3 = 8;
   localparam int B2S_R4 = 7;

   localparam int B2B_R1 = 32;
   localparam int B2B_R2 = 24;
   localparam int B2B_R3 = 16;
   localparam int B2B_R4 = 63;

endpackage

// File: rtl/blake2_g_half.sv
// Combinational half-G: a+=b+m, d=(d^a)>>>r, c+=d, b=(b^c)>>>r.
// sel_i picks rotation pair (RA,RB) when 0 and (RC,RD) when 1; no state, no handshake.
module blake2_g_half #(
   parameter int W  = 32,
   parameter int RA = 16,
   parameter int RB = 12,
   parameter int RC = 8,
   parameter int RD = 7
) (
   input  logic         sel_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   input  logic [W-1:0] d_i,
   input  logic [W-1:0] m_i,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   output logic [W-1:0] c_o,
   output logic [W-1:0] d_o
);

   logic [W-1:0] a_new;
   logic [W-1:0] d_x;
   logic [W-1:0] d_new;
   logic [W-1:0] c_new;
   logic [W-1:0] b_x;

   // Both constant rotations are pure wiring; only the mux costs logic.
   assign a_new = a_i + b_i + m_i;
   assign d_x   = d_i ^ a_new;
   assign d_new = sel_i ? ((d_x >> RC) | (d_x << (W - RC)))
                        : ((d_x >> RA) | (d_x << (W - RA)));
   assign c_new = c_i + d_new;
   assign b_x   = b_i ^ c_new;

   assign a_o = a_new;
   assign d_o = d_new;
   assign c_o = c_new;
   assign b_o = sel_i ? ((b_x >> RD) | (b_x << (W - RD)))
                      : ((b_x >> RB) | (b_x << (W - RB)));

endmodule

// File: rtl/blake2_g_seq.sv
// Sequential BLAKE2 G: one half-G datapath reused over two cycles (x then y).
// Latency 3 edges from accept to valid_o; ready_o=0 while busy, result held until ready_i.
// Optional BLAKE2_G_SEQ_CLR_EN: clear a/b/c/d, m and y registers on a retire without accept.
module blake2_g_seq
   import blake2_pkg::*;
#(
   parameter int W  = B2S_W,
   parameter int R1 = B2S_R1,
   parameter int R2 = B2S_R2,
   parameter int R3 = B2S_R3,
   parameter int R4 = B2S_R4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   input  logic [W-1:0] d_i,
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   output logic [W-1:0] c_o,
   output logic [W-1:0] d_o
);

   g_state_e     state_q, state_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic [W-1:0] m_q, m_d, y_q, y_d;
   logic [W-1:0] a_h, b_h, c_h, d_h;
   logic         accept;
   logic         retire;

   assign ready_o = (state_q == IDLE) | ((state_q == DONE) & ready_i);
   assign valid_o = (state_q == DONE);
   assign accept  = valid_i & ready_o;
   assign retire  = (state_q == DONE) & ready_i;

   assign a_o = a_q;
   assign b_o = b_q;
   assign c_o = c_q;
   assign d_o = d_q;

   blake2_g_half #(
      .W  (W),
      .RA (R1),
      .RB (R2),
      .RC (R3),
      .RD (R4)
   ) u_half (
      .sel_i (state_q == H1),
      .a_i   (a_q),
      .b_i   (b_q),
      .c_i   (c_q),
      .d_i   (d_q),
      .m_i   (m_q),
      .a_o   (a_h),
      .b_o   (b_h),
      .c_o   (c_h),
      .d_o   (d_h)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      m_d     = m_q;
      y_d     = y_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               a_d     = a_i;
               b_d     = b_i;
               c_d     = c_i;
               d_d     = d_i;
               m_d     = x_i;
               y_d     = y_i;
               state_d = H0;
            end else if (retire) begin
               state_d = IDLE;
`ifdef BLAKE2_G_SEQ_CLR_EN
               a_d = '0;
               b_d = '0;
               c_d = '0;
               d_d = '0;
               m_d = '0;
               y_d = '0;
`endif
            end
         end
         H0: begin
            a_d     = a_h;
            b_d     = b_h;
            c_d     = c_h;
            d_d     = d_h;
            m_d     = y_q;
            state_d = H1;
         end
         H1: begin
            a_d     = a_h;
            b_d     = b_h;
            c_d     = c_h;
            d_d     = d_h;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         m_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         m_q     <= m_d;
         y_q     <= y_d;
      end
   end

endmodule

// File: tb/tb_blake2_g_seq.sv
// Bench for blake2_g_seq: BLAKE2s instance (directed vectors) and BLAKE2b instance (random vectors).
// A transaction-level G model predicts results; a negedge process compares every cycle.
module tb_blake2_g_seq;
   import blake2_pkg::*;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic [63:0] d;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        v32_i = 1'b0, rdy32_i = 1'b1, r32_o, v32_o;
   logic [31:0] a32_i = '0, b32_i = '0, c32_i = '0, d32_i = '0, x32_i = '0, y32_i = '0;
   logic [31:0] a32_o, b32_o, c32_o, d32_o;

   logic        v64_i = 1'b0, rdy64_i = 1'b1, r64_o, v64_o;
   logic [63:0] a64_i = '0, b64_i = '0, c64_i = '0, d64_i = '0, x64_i = '0, y64_i = '0;
   logic [63:0] a64_o, b64_o, c64_o, d64_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   blake2_g_seq u32 (
      .clk(clk), .rst(rst), .valid_i(v32_i), .ready_o(r32_o),
      .a_i(a32_i), .b_i(b32_i), .c_i(c32_i), .d_i(d32_i), .x_i(x32_i), .y_i(y32_i),
      .valid_o(v32_o), .ready_i(rdy32_i),
      .a_o(a32_o), .b_o(b32_o), .c_o(c32_o), .d_o(d32_o)
   );

   blake2_g_seq #(.W(B2B_W), .R1(B2B_R1), .R2(B2B_R2), .R3(B2B_R3), .R4(B2B_R4)) u64 (
      .clk(clk), .rst(rst), .valid_i(v64_i), .ready_o(r64_o),
      .a_i(a64_i), .b_i(b64_i), .c_i(c64_i), .d_i(d64_i), .x_i(x64_i), .y_i(y64_i),
      .valid_o(v64_o), .ready_i(rdy64_i),
      .a_o(a64_o), .b_o(b64_o), .c_o(c64_o), .d_o(d64_o)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] rotr(input logic [63:0] v, input int r, input int w);
      logic [63:0] m;
      logic [63:0] t;
      m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      t = v & m;
      return ((t >> r) | (t << (w - r))) & m;
   endfunction

   // Reference G straight from the algorithm definition.
   function automatic res_t gmodel(input int w, input int r1, input int r2, input int r3, input int r4,
                                   input logic [63:0] a0, input logic [63:0] b0, input logic [63:0] c0,
                                   input logic [63:0] d0, input logic [63:0] x, input logic [63:0] y);
      logic [63:0] m, a, b, c, d;
      res_t r;
      m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      a = (a0 + b0 + x) & m;
      d = rotr(d0 ^ a, r1, w);
      c = (c0 + d) & m;
      b = rotr(b0 ^ c, r2, w);
      a = (a + b + y) & m;
      d = rotr(d ^ a, r3, w);
      c = (c + d) & m;
      b = rotr(b ^ c, r4, w);
      r.a = a; r.b = b; r.c = c; r.d = d;
      return r;
   endfunction

   // Transaction model: cd counts edges to result, pend = result on offer, last = visible words.
   int   cd32 = 0, cd64 = 0;
   bit   pend32 = 0, pend64 = 0;
   res_t last32 = '0, last64 = '0;

   always @(posedge clk) begin
      bit rdy_m, acc;
      if (rst) begin
         cd32 = 0; pend32 = 0; last32 = '0;
         cd64 = 0; pend64 = 0; last64 = '0;
      end else begin
         rdy_m = (cd32 == 0 && !pend32) || (pend32 && rdy32_i);
         acc   = v32_i && rdy_m;
         if (pend32 && rdy32_i) begin
            pend32 = 0;
`ifdef BLAKE2_G_SEQ_CLR_EN
            if (!acc) last32 = '0;
`endif
         end
         if (cd32 > 0) begin
            cd32--;
            if (cd32 == 0) pend32 = 1;
         end
         if (acc) begin
            cd32   = 2;
            last32 = gmodel(32, 16, 12, 8, 7, {32'b0, a32_i}, {32'b0, b32_i}, {32'b0, c32_i},
                            {32'b0, d32_i}, {32'b0, x32_i}, {32'b0, y32_i});
         end

         rdy_m = (cd64 == 0 && !pend64) || (pend64 && rdy64_i);
         acc   = v64_i && rdy_m;
         if (pend64 && rdy64_i) begin
            pend64 = 0;
`ifdef BLAKE2_G_SEQ_CLR_EN
            if (!acc) last64 = '0;
`endif
         end
         if (cd64 > 0) begin
            cd64--;
            if (cd64 == 0) pend64 = 1;
         end
         if (acc) begin
            cd64   = 2;
            last64 = gmodel(64, 32, 24, 16, 63, a64_i, b64_i, c64_i, d64_i, x64_i, y64_i);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("valid32", {63'b0, v32_o}, {63'b0, pend32});
         chk("ready32", {63'b0, r32_o}, {63'b0, (cd32 == 0 && !pend32) || (pend32 && rdy32_i)});
         if (cd32 == 0) begin
            chk("a32", {32'b0, a32_o}, last32.a);
            chk("b32", {32'b0, b32_o}, last32.b);
            chk("c32", {32'b0, c32_o}, last32.c);
            chk("d32", {32'b0, d32_o}, last32.d);
         end
         chk("valid64", {63'b0, v64_o}, {63'b0, pend64});
         chk("ready64", {63'b0, r64_o}, {63'b0, (cd64 == 0 && !pend64) || (pend64 && rdy64_i)});
         if (cd64 == 0) begin
            chk("a64", a64_o, last64.a);
            chk("b64", b64_o, last64.b);
            chk("c64", c64_o, last64.c);
            chk("d64", d64_o, last64.d);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic acc32(input logic [31:0] a, b, c, d, x, y);
      bit got;
      got = 0;
      v32_i = 1; a32_i = a; b32_i = b; c32_i = c; d32_i = d; x32_i = x; y32_i = y;
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         got = r32_o;
         @(posedge clk); #1;
      end
      v32_i = 0;
      chk("acc32_timeout", {63'b0, got}, 64'd1);
   endtask

   task automatic wait_v32(output int n);
      n = 1;
      while (!v32_o && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic chk_out32(input string nm, input logic [31:0] a, b, c, d);
      chk({nm, "_a"}, {32'b0, a32_o}, {32'b0, a});
      chk({nm, "_b"}, {32'b0, b32_o}, {32'b0, b});
      chk({nm, "_c"}, {32'b0, c32_o}, {32'b0, c});
      chk({nm, "_d"}, {32'b0, d32_o}, {32'b0, d});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      res_t r;
      logic [31:0] ha, hb, hc, hd;

      // Pin the reference model on the hand-derived vectors.
      r = gmodel(32, 16, 12, 8, 7, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
      chk("model_v1_b", r.b, 64'h20220202);
      r = gmodel(32, 16, 12, 8, 7, 64'hFFFFFFFF, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0);
      chk("model_wrap_a", r.a, 64'h00100000);

      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      #1;
      chk("rst_valid", {63'b0, v32_o}, 64'd0);
      chk("rst_ready", {63'b0, r32_o}, 64'd1);
      chk_out32("rst", 32'h0, 32'h0, 32'h0, 32'h0);
      @(posedge clk); #1;

      // Reset in the middle of an operation drops it.
      acc32(32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f, 32'hf0f0f0f0, 32'h11111111, 32'h22222222);
      rst = 1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 0;
      #1;
      chk("midrst_valid", {63'b0, v32_o}, 64'd0);
      chk("midrst_ready", {63'b0, r32_o}, 64'd1);
      chk_out32("midrst", 32'h0, 32'h0, 32'h0, 32'h0);
      repeat (5) @(posedge clk);
      #1;

      // Single word seed, immediate consume.
      rdy32_i = 1;
      acc32(32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_v32(n);
      chk("lat_v1", 64'(n), 64'd3);
      chk_out32("v1", 32'h00000011, 32'h20220202, 32'h11010100, 32'h11000100);
      @(posedge clk); #1;
      chk("v1_idle_valid", {63'b0, v32_o}, 64'd0);
`ifdef BLAKE2_G_SEQ_CLR_EN
      chk_out32("v1_idle", 32'h0, 32'h0, 32'h0, 32'h0);
`else
      chk_out32("v1_idle", 32'h00000011, 32'h20220202, 32'h11010100, 32'h11000100);
`endif

      // Carry out of the top bit is discarded.
      acc32(32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_v32(n);
      chk("lat_wrap", 64'(n), 64'd3);
      chk_out32("wrap", 32'h00100000, 32'h00002020, 32'h00001000, 32'h00001000);
      @(posedge clk); #1;

      // Backpressure: hold in DONE, then retire and accept on the same edge.
      rdy32_i = 0;
      acc32(32'hdeadbeef, 32'hcafef00d, 32'h01234567, 32'h89abcdef, 32'h0badc0de, 32'h600dcafe);
      wait_v32(n);
      chk("lat_bp", 64'(n), 64'd3);
      ha = a32_o; hb = b32_o; hc = c32_o; hd = d32_o;
      r = gmodel(32, 16, 12, 8, 7, 64'hdeadbeef, 64'hcafef00d, 64'h01234567, 64'h89abcdef,
                 64'h0badc0de, 64'h600dcafe);
      chk("bp_res_a", {32'b0, ha}, r.a);
      chk("bp_res_d", {32'b0, hd}, r.d);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {63'b0, v32_o}, 64'd1);
         chk("bp_hold_ready", {63'b0, r32_o}, 64'd0);
         chk_out32("bp_hold", ha, hb, hc, hd);
      end
      rdy32_i = 1;
      acc32(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6);
      chk("bp_b2b_valid", {63'b0, v32_o}, 64'd0);
      wait_v32(n);
      chk("lat_b2b", 64'(n), 64'd3);
      r = gmodel(32, 16, 12, 8, 7, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6);
      chk_out32("b2b", r.a[31:0], r.b[31:0], r.c[31:0], r.d[31:0]);
      @(posedge clk); #1;

      // BLAKE2b: random operands and random consumer stalls.
      for (int i = 0; i < 1000; i++) begin
         bit got;
         got = 0;
         v64_i = 1;
         a64_i = {$urandom, $urandom}; b64_i = {$urandom, $urandom};
         c64_i = {$urandom, $urandom}; d64_i = {$urandom, $urandom};
         x64_i = {$urandom, $urandom}; y64_i = {$urandom, $urandom};
         for (int k = 0; k < 40 && !got; k++) begin
            rdy64_i = ($urandom_range(0, 3) != 0);
            #1;
            got = r64_o;
            @(posedge clk); #1;
         end
         if (!got) chk("acc64_timeout", {63'b0, got}, 64'd1);
         v64_i = 0;
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end
      rdy64_i = 1;
      repeat (6) @(posedge clk);
      #1;
      chk("b64_drained", {63'b0, v64_o}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/blake2_g_seq.md
Name: blake2_g_seq

Overview:
- Sequential, handshaked BLAKE2 G mixing unit, parametrised for BLAKE2s (W=32) or BLAKE2b (W=64) through width and rotation parameters.
- Computes G in two cycles by reusing one half-G datapath: first half uses message word x with R1/R2, second half uses y with R3/R4.
- Sits between the round scheduler (supplies a,b,c,d,x,y) and the working-vector register file.
- Valid/ready on both sides, so the scheduler can stall or run back-to-back.

Parameters:
- W, 32, word width; legal values 32 (BLAKE2s) and 64 (BLAKE2b).
- R1, 16, first rotation (BLAKE2b: 32).
- R2, 12, second rotation (BLAKE2b: 24).
- R3, 8, third rotation (BLAKE2b: 16).
- R4, 7, fourth rotation (BLAKE2b: 63).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept operands this cycle.
- a_i, b_i, c_i, d_i  in  W each  working-vector words.
- x_i, y_i  in  W each  message words.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- a_o, b_o, c_o, d_o  out  W each  mixed words, driven directly from registers.

Behaviour:
- FSM states:
  - IDLE, H0, H1: data phases.
  - DONE: output state; the FSM sits here while valid_o=1.
- Reset (rst=1 at an edge): state=IDLE; a_o/b_o/c_o/d_o=0; valid_o=0; ready_o=1; internal y register=0. Reset wins over any handshake in the same cycle. Reset mid-operation abandons the operation and emits no valid_o.
- ready_o = (state==IDLE) | (state==DONE & ready_i). It is combinational from state and ready_i only, never from valid_i.
- Accept occurs when valid_i & ready_o at an edge:
  - capture a_i..d_i into the a/b/c/d registers;
  - capture y_i into y_q;
  - capture x_i into m_q;
  - state <- H0.
- H0 edge: a/b/c/d <- half(a,b,c,d,m_q,R1,R2); m_q <- y_q; state <- H1.
- H1 edge: a/b/c/d <- half(a,b,c,d,m_q,R3,R4); state <- DONE.
- half(a,b,c,d,m,Ra,Rb):
  - a' = a+b+m mod 2^W
  - d' = (d^a') rotr Ra
  - c' = c+d' mod 2^W
  - b' = (b^c') rotr Rb
- All carries are discarded; rotations are by constant amounts.
- Latency: valid_o rises 3 edges after the accept edge (accept, H0, H1). Throughput: one G per 3 cycles when back-to-back.
- DONE with ready_i=0: hold valid_o and outputs stable (no change until handshake).
- DONE with ready_i=1, valid_i=0: state <- IDLE; valid_o=0 next cycle.
- DONE with ready_i=1, valid_i=1: result retires and the new operands are accepted at the same edge; state <- H0.
- valid_i while in H0/H1: ignored (ready_o=0). The producer must hold it.
- valid_o=1 exactly when state==DONE.

Optional Feature:
- Macro BLAKE2_G_SEQ_CLR_EN.
- Defined: on the retire edge (DONE & ready_i) without a simultaneous accept, the a/b/c/d, m_q and y_q registers are cleared to 0. In IDLE, outputs read 0 (key-material hygiene).
- Undefined: registers hold the last result in IDLE; no clear logic is synthesised.
- Behaviour with valid_o=1 is identical in both builds.

Decomposition:
- Package blake2_pkg:
  - FSM state encoding (2-bit: IDLE=0, H0=1, H1=2, DONE=3);
  - rotation constant sets for BLAKE2s (16,12,8,7) and BLAKE2b (32,24,16,63);
  - widths 32/64.
- Sub-module blake2_g_half: purely combinational, parameters W/RA/RB, inputs a,b,c,d,m, outputs a',b',c',d'.
  - Instantiate it once.
  - Select the rotation pair by phase, with two constant-rotated wire sets muxed on state.

Test Plan:
- Reset: assert rst 2 cycles mid-H0 -> valid_o=0, ready_o=1, all outputs 0, state IDLE next cycle; no spurious valid_o.
- W=32, a=1, b=c=d=x=y=0, ready_i=1 -> valid_o 3 edges after accept; a_o=0x00000011, b_o=0x20220202, c_o=0x11010100, d_o=0x11000100.
- Wrap-around, W=32: a=0xFFFFFFFF, b=1, c=d=x=y=0 -> a_o=0x00100000, b_o=0x00002020, c_o=0x00001000, d_o=0x00001000.
- Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o and outputs stable, ready_o=0. Then ready_i=1 with valid_i=1 -> same-edge retire+accept, next result 3 edges later.
- W=64 with rotations 32/24/16/63: 1000 random vectors -> match software BLAKE2b G model bit-exact.
- BLAKE2_G_SEQ_CLR_EN defined: after retire with valid_i=0 -> a_o..d_o=0 in IDLE. Undefined -> hold last result.
